// File: rtl/ntr_host_master.sv
// Purpose : host-side NTR cartridge bus initiator; sends an 8-byte command, then reads resp_len bytes.
// Latency : bus activity starts the cycle after an accepted start; done after CLK_DIV*(18 [+ 2*resp_len + 1]) + 1 cycles.
// Backpressure: none; start is only taken in IDLE with done low, any other start pulse is dropped.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   start, cmd,        request pulse; cmd (MSB byte first) and resp_len are captured when start is accepted
//   resp_len
//   busy, done         busy from the cycle after accepted start until done; done is a one-cycle pulse
//   resp_data,         last captured response byte, with a one-cycle pulse per byte
//   resp_valid
//   ntr_clk, ntr_cs1   bus clock (idles high) and active-low chip select
//   ntr_data_out/oe/in split bidirectional data bus; oe high while the host drives it

module ntr_host_master #(
    parameter int CLK_DIV = 4,   // ntr_clk half-period in clk cycles; even, >= 2
    parameter int LEN_W   = 12   // width of the response byte count
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [63:0]      cmd,
    input  logic [LEN_W-1:0] resp_len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       resp_data,
    output logic             resp_valid,
    output logic             ntr_clk,
    output logic             ntr_cs1,
    output logic [7:0]       ntr_data_out,
    output logic             ntr_data_oe,
    input  logic [7:0]       ntr_data_in
);

    // cnt spans a full byte slot (2*CLK_DIV cycles); shorter phases reuse it.
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] MID        = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] PHASE_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HIGH_START = CW'(CLK_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_TURN,
        S_RESP,
        S_HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [2:0]       byte_idx, byte_nxt;
    logic [LEN_W-1:0] resp_idx, resp_idx_nxt;
    logic [63:0]      cmd_q, cmd_q_nxt;
    logic [LEN_W-1:0] len_q, len_q_nxt;

    logic             busy_nxt, done_nxt, resp_valid_nxt;
    logic [7:0]       resp_data_nxt;
    logic             ntr_clk_nxt, ntr_cs1_nxt, ntr_data_oe_nxt;
    logic [7:0]       ntr_data_out_nxt;

    function automatic logic [7:0] cmd_byte(input logic [63:0] c, input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = c[63:56];
            3'd1:    b = c[55:48];
            3'd2:    b = c[47:40];
            3'd3:    b = c[39:32];
            3'd4:    b = c[31:24];
            3'd5:    b = c[23:16];
            3'd6:    b = c[15:8];
            default: b = c[7:0];
        endcase
        return b;
    endfunction

    // Next-state and sequencing counters.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        byte_nxt     = byte_idx;
        resp_idx_nxt = resp_idx;
        cmd_q_nxt    = cmd_q;
        len_q_nxt    = len_q;
        done_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                // done is high in the first IDLE cycle; a start there is dropped.
                if (start && !done) begin
                    state_nxt    = S_SETUP;
                    cnt_nxt      = '0;
                    byte_nxt     = '0;
                    resp_idx_nxt = '0;
                    cmd_q_nxt    = cmd;
                    len_q_nxt    = resp_len;
                end
            end
            S_SETUP: begin
                if (cnt == PHASE_LAST) begin
                    state_nxt = S_CMD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_CMD: begin
                if (cnt == SLOT_LAST) begin
                    cnt_nxt = '0;
                    if (byte_idx == 3'd7) begin
                        state_nxt = (len_q != '0) ? S_TURN : S_HOLD;
                    end else begin
                        byte_nxt = byte_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_TURN: begin
                if (cnt == PHASE_LAST) begin
                    state_nxt = S_RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RESP: begin
                if (cnt == SLOT_LAST) begin
                    cnt_nxt = '0;
                    if (resp_idx == len_q - LEN_W'(1)) begin
                        state_nxt = S_HOLD;
                    end else begin
                        resp_idx_nxt = resp_idx + LEN_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt == PHASE_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output values are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        busy_nxt         = (state_nxt != S_IDLE);
        ntr_cs1_nxt      = (state_nxt == S_IDLE);
        ntr_data_oe_nxt  = (state_nxt == S_SETUP) || (state_nxt == S_CMD);
        ntr_clk_nxt      = !(((state_nxt == S_CMD) || (state_nxt == S_RESP)) && (cnt_nxt < HIGH_START));
        ntr_data_out_nxt = ntr_data_out;
        resp_data_nxt    = resp_data;
        resp_valid_nxt   = 1'b0;

        if (!ntr_data_oe_nxt) begin
            ntr_data_out_nxt = 8'h00;
        end else if (state == S_IDLE) begin
            ntr_data_out_nxt = cmd[63:56];
        end else if ((state_nxt == S_CMD) && (cnt_nxt == MID)) begin
            // Mid-low change point keeps data stable around both ntr_clk edges.
            ntr_data_out_nxt = cmd_byte(cmd_q, byte_nxt);
        end

        // Sample the cartridge on the same clk edge that raises ntr_clk.
        if ((state == S_RESP) && (cnt == PHASE_LAST)) begin
            resp_data_nxt  = ntr_data_in;
            resp_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            byte_idx     <= '0;
            resp_idx     <= '0;
            cmd_q        <= '0;
            len_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            resp_data    <= 8'h00;
            resp_valid   <= 1'b0;
            ntr_clk      <= 1'b1;
            ntr_cs1      <= 1'b1;
            ntr_data_out <= 8'h00;
            ntr_data_oe  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            byte_idx     <= byte_nxt;
            resp_idx     <= resp_idx_nxt;
            cmd_q        <= cmd_q_nxt;
            len_q        <= len_q_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            resp_data    <= resp_data_nxt;
            resp_valid   <= resp_valid_nxt;
            ntr_clk      <= ntr_clk_nxt;
            ntr_cs1      <= ntr_cs1_nxt;
            ntr_data_out <= ntr_data_out_nxt;
            ntr_data_oe  <= ntr_data_oe_nxt;
        end
    end

endmodule

// File: tb/tb_ntr_host_master.sv
// Purpose : exercises ntr_host_master at CLK_DIV=4 and CLK_DIV=2 against a cartridge-side model.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).

module tb_ntr_host_master;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] cmd;
    logic [11:0] resp_len;
    logic [7:0]  din;
    logic        sel;          // 0: observe CLK_DIV=4 instance, 1: CLK_DIV=2 instance

    logic        start4, busy4, done4, rvld4, nclk4, cs4, oe4;
    logic [7:0]  rdata4, dout4;
    logic        start2, busy2, done2, rvld2, nclk2, cs2, oe2;
    logic [7:0]  rdata2, dout2;

    logic        m_busy, m_done, m_rvld, m_clk, m_cs1, m_oe;
    logic [7:0]  m_rdata, m_dout;

    int          checks;
    int          errors;
    logic [7:0]  exp_resp[$];

    assign start4  = start & ~sel;
    assign start2  = start & sel;
    assign m_busy  = sel ? busy2  : busy4;
    assign m_done  = sel ? done2  : done4;
    assign m_rvld  = sel ? rvld2  : rvld4;
    assign m_clk   = sel ? nclk2  : nclk4;
    assign m_cs1   = sel ? cs2    : cs4;
    assign m_oe    = sel ? oe2    : oe4;
    assign m_rdata = sel ? rdata2 : rdata4;
    assign m_dout  = sel ? dout2  : dout4;

    ntr_host_master #(.CLK_DIV(4), .LEN_W(12)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .cmd(cmd), .resp_len(resp_len),
        .busy(busy4), .done(done4), .resp_data(rdata4), .resp_valid(rvld4),
        .ntr_clk(nclk4), .ntr_cs1(cs4), .ntr_data_out(dout4), .ntr_data_oe(oe4),
        .ntr_data_in(din)
    );

    ntr_host_master #(.CLK_DIV(2), .LEN_W(12)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cmd(cmd), .resp_len(resp_len),
        .busy(busy2), .done(done2), .resp_data(rdata2), .resp_valid(rvld2),
        .ntr_clk(nclk2), .ntr_cs1(cs2), .ntr_data_out(dout2), .ntr_data_oe(oe2),
        .ntr_data_in(din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte k of a command as it should appear on the bus (k=0 is the top byte).
    function automatic logic [7:0] ref_byte(input logic [63:0] c, input int k);
        logic [63:0] s;
        s = c >> (56 - 8 * k);
        return s[7:0];
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic fill_resp(input int n);
        exp_resp = {};
        for (int i = 0; i < n; i++) exp_resp.push_back(8'($urandom_range(0, 255)));
    endtask

    // Runs one transaction on the selected instance, acting as the cartridge and checking the bus.
    // With ignore_mode, start is pulsed with junk cmd/resp_len while busy and also in the done cycle.
    task automatic run_txn(input logic [63:0] c, input bit ignore_mode, input string name);
        int d, len, i, rises, falls, fall_cyc, cs1_low, ridx, budget, exp_low, k;
        logic prev_clk;
        logic [7:0] prev_dat, eb, pb;
        logic [7:0] got[$];
        bit fin;
        d   = sel ? 2 : 4;
        len = exp_resp.size();
        @(negedge clk);
        start = 1'b1; cmd = c; resp_len = 12'(len);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (m_busy !== 1'b1 || m_cs1 !== 1'b0 || m_oe !== 1'b1 || m_clk !== 1'b1 || m_dout !== c[63:56]) begin
            errors++;
            $display("FAIL %s first_cycle: busy=%b cs1=%b oe=%b clk=%b dout=%h, want 1 0 1 1 %h",
                     name, m_busy, m_cs1, m_oe, m_clk, m_dout, c[63:56]);
        end
        prev_clk = m_clk; prev_dat = m_dout;
        cs1_low = 1; i = 0; rises = 0; falls = 0; fall_cyc = -1000; ridx = 0; fin = 0;
        budget = d * (20 + 2 * len) + 20;
        while (!fin && i < budget) begin
            @(negedge clk);
            i++;
            if (ignore_mode) begin
                if (m_done) begin
                    start = 1'b1;
                end else if (m_busy && $urandom_range(0, 3) == 0) begin
                    start = 1'b1; cmd = rand64(); resp_len = 12'($urandom_range(0, 4095));
                end else begin
                    start = 1'b0;
                end
            end
            if (!m_cs1) cs1_low++;
            if (m_rvld) got.push_back(m_rdata);
            if (prev_clk && !m_clk) begin
                fall_cyc = i;
                falls++;
                if (!m_oe && ridx < len) begin
                    din = exp_resp[ridx];
                    ridx++;
                end
            end
            if (!prev_clk && m_clk) begin
                checks++;
                if (i - fall_cyc != d) begin
                    errors++;
                    $display("FAIL %s low_phase rise %0d: %0d cycles, want %0d", name, rises, i - fall_cyc, d);
                end
                checks++;
                if (m_dout !== prev_dat) begin
                    errors++;
                    $display("FAIL %s data_stable rise %0d: %h then %h", name, rises, prev_dat, m_dout);
                end
                checks++;
                if (rises < 8) begin
                    eb = ref_byte(c, rises);
                    if (m_oe !== 1'b1 || m_dout !== eb) begin
                        errors++;
                        $display("FAIL %s cmd_byte %0d: oe=%b dout=%h, want oe=1 dout=%h", name, rises, m_oe, m_dout, eb);
                    end
                end else if (m_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL %s oe_resp rise %0d: oe=%b, want 0", name, rises, m_oe);
                end
                rises++;
            end
            if (m_oe && !m_clk && falls >= 1 && i - fall_cyc == d / 2) begin
                k  = falls - 1;
                eb = ref_byte(c, k);
                pb = ref_byte(c, (k > 0) ? k - 1 : 0);
                checks++;
                if (m_dout !== eb || prev_dat !== pb) begin
                    errors++;
                    $display("FAIL %s change_point slot %0d: before=%h at=%h, want %h %h", name, k, prev_dat, m_dout, pb, eb);
                end
            end
            if (m_done) begin
                fin = 1;
                checks++;
                if (m_busy !== 1'b0 || m_cs1 !== 1'b1 || m_clk !== 1'b1 || m_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_cycle: busy=%b cs1=%b clk=%b oe=%b, want 0 1 1 0", name, m_busy, m_cs1, m_clk, m_oe);
                end
            end
            prev_clk = m_clk;
            prev_dat = m_dout;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, budget);
        end
        exp_low = d * 18 + ((len > 0) ? d * (2 * len + 1) : 0);
        checks++;
        if (cs1_low != exp_low) begin
            errors++;
            $display("FAIL %s cs1_low: %0d cycles, want %0d", name, cs1_low, exp_low);
        end
        checks++;
        if (rises != 8 + len) begin
            errors++;
            $display("FAIL %s rise_count: %0d, want %0d", name, rises, 8 + len);
        end
        checks++;
        if (got.size() != len) begin
            errors++;
            $display("FAIL %s resp_count: %0d, want %0d", name, got.size(), len);
        end
        for (int j = 0; j < len && j < got.size(); j++) begin
            checks++;
            if (got[j] !== exp_resp[j]) begin
                errors++;
                $display("FAIL %s resp_byte %0d: %h, want %h", name, j, got[j], exp_resp[j]);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_clk, m_cs1, m_oe, m_busy, m_done, m_rvld} !== 6'b110000 || m_dout !== 8'h00 || m_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: clk=%b cs1=%b oe=%b busy=%b done=%b rvld=%b dout=%h rdata=%h, want 1 1 0 0 0 0 00 00",
                     m_clk, m_cs1, m_oe, m_busy, m_done, m_rvld, m_dout, m_rdata);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({m_clk, m_cs1, m_oe, m_busy} !== 4'b1100) begin
                errors++;
                bad++;
                if (bad < 4) $display("FAIL reset_idle cycle %0d: clk=%b cs1=%b oe=%b busy=%b, want 1 1 0 0", i, m_clk, m_cs1, m_oe, m_busy);
            end
        end
    endtask

    task automatic test_cmd_only();
        fill_resp(0);
        run_txn(64'hFF00_0000_0000_0000, 1'b0, "cmd_only");
    endtask

    task automatic test_read();
        exp_resp = {8'h11, 8'h22, 8'h33, 8'h44};
        run_txn(64'hB700_0000_0001_FF00, 1'b0, "read4");
    endtask

    task automatic test_async_reset();
        int n, i, ridx;
        logic prev_clk;
        fill_resp(4);
        @(negedge clk);
        start = 1'b1; cmd = rand64(); resp_len = 12'd4;
        @(negedge clk);
        start = 1'b0;
        n = 0; i = 0; ridx = 0; prev_clk = m_clk;
        while (n < 2 && i < 400) begin
            @(negedge clk);
            i++;
            if (prev_clk && !m_clk && !m_oe && ridx < 4) begin
                din = exp_resp[ridx];
                ridx++;
            end
            if (m_rvld) n++;
            prev_clk = m_clk;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL async_reach_resp: %0d bytes seen, want 2", n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_cs1, m_clk, m_busy, m_oe} !== 4'b1100) begin
            errors++;
            $display("FAIL async_reset: cs1=%b clk=%b busy=%b oe=%b, want 1 1 0 0", m_cs1, m_clk, m_busy, m_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_resp(3);
        run_txn(rand64(), 1'b0, "after_reset");
    endtask

    task automatic test_start_ignored();
        int d;
        d = sel ? 2 : 4;
        fill_resp(2);
        run_txn(rand64(), 1'b1, "ignore");
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2 * d + 4; i++) begin
            checks++;
            if (m_busy !== 1'b0 || m_cs1 !== 1'b1 || m_done !== 1'b0) begin
                errors++;
                $display("FAIL ignore_idle cycle %0d: busy=%b cs1=%b done=%b, want 0 1 0", i, m_busy, m_cs1, m_done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        fill_resp(1);
        run_txn(rand64(), 1'b0, "b2b_first");
        fill_resp(2);
        run_txn(rand64(), 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            fill_resp($urandom_range(0, 6));
            run_txn(rand64(), 1'b0, "random");
        end
    endtask

    task automatic test_clkdiv2();
        @(negedge clk);
        sel = 1'b1;
        fill_resp(1);
        run_txn(rand64(), 1'b0, "div2_len1");
        fill_resp($urandom_range(0, 5));
        run_txn(rand64(), 1'b0, "div2_random");
        test_start_ignored();
        @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        start    = 1'b0;
        cmd      = '0;
        resp_len = '0;
        din      = 8'h00;
        sel      = 1'b0;
        test_reset();
        test_cmd_only();
        test_read();
        test_async_reset();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_clkdiv2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
